// File: rtl/stream_load_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_load_pkg
// Brief    : Shared state encoding and mask helper for the stream load sequencer
// Revision : 1.0
// ============================================================================
package stream_load_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SELECT = 2'd1,
      ST_LOAD   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int MAX_TARGETS = 32;
   localparam int MAX_TGT_W   = 5;

   typedef struct packed {
      logic [MAX_TGT_W-1:0]   idx;
      logic [MAX_TARGETS-1:0] rest;
   } lsb_t;

   // Index of the lowest set bit plus the mask with that bit cleared.
   function automatic lsb_t lowest_set_bit(input logic [MAX_TARGETS-1:0] mask);
      lsb_t res;
      res.idx  = '0;
      res.rest = mask;
      for (int i = MAX_TARGETS - 1; i >= 0; i--) begin
         if (mask[i]) res.idx = MAX_TGT_W'(i);
      end
      res.rest[res.idx] = 1'b0;
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/counter_mod.sv
`default_nettype none
// ============================================================================
// Module   : counter_mod
// Brief    : Modulo-MOD up counter with synchronous clear and terminal flag
// Revision : 1.0
// ============================================================================
module counter_mod #(
   parameter int MOD   = 4,
   parameter int CNT_W = (MOD > 1) ? $clog2(MOD) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             reset_count,
   input  logic             up,
   output logic [CNT_W-1:0] count,
   output logic             at_max
);

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(MOD - 1);

   logic [CNT_W-1:0] r_count;

   assign count  = r_count;
   assign at_max = (r_count == C_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (reset_count) begin
         r_count <= '0;
      end else if (up) begin
         r_count <= at_max ? '0 : r_count + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/stream_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stream_load_sequencer
// Brief    : Walks masked targets in ascending order, routing stream beats
//            into each target's row/col element write port
// Revision : 1.0
// ============================================================================
module stream_load_sequencer
   import stream_load_pkg::*;
#(
   parameter  int NUM_TARGETS    = 3,
   parameter  int NUM_ROWS       = 4,
   parameter  int NUM_COLS       = 5,
   parameter  int WIDTH          = 32,
   localparam int TGT_W          = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1,
   localparam int ROW_ADDR_WIDTH = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
   localparam int COL_ADDR_WIDTH = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      abort,
   input  logic [NUM_TARGETS-1:0]    target_mask,
   output logic                      busy,
   output logic                      done,
   output logic                      target_done,
   output logic [TGT_W-1:0]          target_done_idx,
   output logic [TGT_W-1:0]          cur_target,
   output logic                      ds_next_data,
   input  logic [WIDTH-1:0]          ds_out,
   input  logic                      ds_valid,
   output logic [NUM_TARGETS-1:0]    write_sel,
   output logic [ROW_ADDR_WIDTH-1:0] write_row_addr,
   output logic [COL_ADDR_WIDTH-1:0] write_col_addr,
   output logic [WIDTH-1:0]          write_data
);

   state_t                   r_state;
   logic [NUM_TARGETS-1:0]   r_mask;
   logic [TGT_W-1:0]         r_cur_target;
   logic [TGT_W-1:0]         r_target_done_idx;
   logic                     r_busy;
   logic                     r_done;
   logic                     r_target_done;

   logic                     w_accept;
   logic                     w_clear;
   logic                     w_col_max;
   logic                     w_row_max;
   logic                     w_last;
   lsb_t                     w_lsb;
   logic                     w_unused_lsb;

   // abort wins over a coincident beat, so that beat is never written
   assign w_accept     = (r_state == ST_LOAD) && ds_valid && !abort;
   assign w_clear      = (r_state == ST_SELECT) || abort;
   assign w_last       = w_accept && w_col_max && w_row_max;
   assign w_lsb        = lowest_set_bit(MAX_TARGETS'(r_mask));
   assign w_unused_lsb = ^w_lsb;

   counter_mod #(.MOD(NUM_COLS), .CNT_W(COL_ADDR_WIDTH)) u_col_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .reset_count (w_clear),
      .up          (w_accept),
      .count       (write_col_addr),
      .at_max      (w_col_max)
   );

   counter_mod #(.MOD(NUM_ROWS), .CNT_W(ROW_ADDR_WIDTH)) u_row_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .reset_count (w_clear),
      .up          (w_accept && w_col_max),
      .count       (write_row_addr),
      .at_max      (w_row_max)
   );

   always_comb begin
      write_sel = '0;
      for (int i = 0; i < NUM_TARGETS; i++) begin
         write_sel[i] = w_accept && (r_cur_target == TGT_W'(i));
      end
   end

   assign ds_next_data    = (r_state == ST_LOAD);
   assign write_data      = ds_out;
   assign busy            = r_busy;
   assign done            = r_done;
   assign target_done     = r_target_done;
   assign target_done_idx = r_target_done_idx;
   assign cur_target      = r_cur_target;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state           <= ST_IDLE;
         r_mask            <= '0;
         r_cur_target      <= '0;
         r_target_done_idx <= '0;
         r_busy            <= 1'b0;
         r_done            <= 1'b0;
         r_target_done     <= 1'b0;
      end else begin
         r_done        <= 1'b0;
         r_target_done <= 1'b0;
         if (abort && r_state != ST_IDLE) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (start) begin
                     r_mask  <= target_mask;
                     r_busy  <= 1'b1;
                     r_state <= ST_SELECT;
                  end
               end
               ST_SELECT: begin
                  if (r_mask == '0) begin
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_cur_target <= w_lsb.idx[TGT_W-1:0];
                     r_mask       <= w_lsb.rest[NUM_TARGETS-1:0];
                     r_state      <= ST_LOAD;
                  end
               end
               ST_LOAD: begin
                  if (w_last) begin
                     r_target_done     <= 1'b1;
                     r_target_done_idx <= r_cur_target;
                     if (r_mask != '0) begin
                        r_state <= ST_SELECT;
                     end else begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                     end
                  end
               end
               ST_DONE: begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire
